// File: rtl/ddr_arb_pkg.sv
// Shared encodings for the DDR request arbiter: FSM states, requester indices, priority order.
// Pure declarations; no logic, latency or backpressure of its own.
package ddr_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] REQ_INS   = 2'd0;
    localparam logic [1:0] REQ_STORE = 2'd1;
    localparam logic [1:0] REQ_JMP   = 2'd2;
    localparam logic [1:0] REQ_DREAD = 2'd3;

    // Highest priority first; consulted only when no requester is starving.
    localparam logic [1:0] PRIO_ORDER [NUM_REQ] = '{REQ_JMP, REQ_STORE, REQ_DREAD, REQ_INS};

endpackage

// File: rtl/ddr_req_arbiter_if.sv
// Cache-side requester and DDR-interface-side signals of the request arbiter.
// Slave modport is the arbiter's view; master modport is the surrounding logic.
interface ddr_req_arbiter_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 8
);
    import ddr_arb_pkg::*;

    logic                      init_done;
    logic                      ins_read_req;
    logic [DDR_ADDR_WIDTH-1:0] ins_read_addr;
    logic [LEN_WIDTH-1:0]      ins_read_len;
    logic                      data_store_req;
    logic [DDR_ADDR_WIDTH-1:0] data_write_addr;
    logic                      jmp_addr_read_req;
    logic [DDR_ADDR_WIDTH-1:0] jmp_read_addr;
    logic                      data_read_req;
    logic [DDR_ADDR_WIDTH-1:0] data_read_addr;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        dn_req_vec;
    logic [DDR_ADDR_WIDTH-1:0] dn_read_addr;
    logic [DDR_ADDR_WIDTH-1:0] dn_write_addr;
    logic [LEN_WIDTH-1:0]      dn_ins_len;
    logic                      dn_start;
    logic                      dn_done;
    logic                      timeout_err;
    logic                      busy;

    modport slave (
        input  init_done, ins_read_req, ins_read_addr, ins_read_len,
               data_store_req, data_write_addr, jmp_addr_read_req, jmp_read_addr,
               data_read_req, data_read_addr, dn_start, dn_done,
        output req_done, dn_req_vec, dn_read_addr, dn_write_addr, dn_ins_len,
               timeout_err, busy
    );

    modport master (
        output init_done, ins_read_req, ins_read_addr, ins_read_len,
               data_store_req, data_write_addr, jmp_addr_read_req, jmp_read_addr,
               data_read_req, data_read_addr, dn_start, dn_done,
        input  req_done, dn_req_vec, dn_read_addr, dn_write_addr, dn_ins_len,
               timeout_err, busy
    );

endinterface

// File: rtl/ddr_arb_pick.sv
// Combinational winner select: starving requesters first (lowest index), then fixed priority.
// Zero latency; no backpressure, the caller decides when the result is used.
module ddr_arb_pick
    import ddr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] starve,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && starve[i]) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            if (!found && req[PRIO_ORDER[p]]) begin
                idx   = PRIO_ORDER[p];
                found = 1'b1;
            end
        end
        if (found) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Serialises four cache requesters onto one one-hot DDR request, one outstanding at a time.
// Grant 1 cycle after sampling a request; request held in ISSUE until dn_start or timeout.
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int          DDR_ADDR_WIDTH = 28,
    parameter int          LEN_WIDTH      = 8,
    parameter logic [3:0]  STARVE_LIMIT   = 4'd8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input logic              mem_clk,
    input logic              rst,
    ddr_req_arbiter_if.slave bus
);

    arb_state_t                state, state_nxt;
    logic [NUM_REQ-1:0]        req, starve, pick_gnt, win_oh, req_done_q;
    logic [1:0]                pick_idx;
    logic [3:0]                loss_cnt [NUM_REQ];
    logic [15:0]               timer;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic                      timeout_q, grant_ev, timeout_hit;

    assign req = {bus.data_read_req, bus.jmp_addr_read_req, bus.data_store_req, bus.ins_read_req};

    always_comb begin
        starve = '0;
        for (int i = 0; i < NUM_REQ; i++) starve[i] = (loss_cnt[i] == STARVE_LIMIT);
    end

    ddr_arb_pick u_pick (
        .req    (req),
        .starve (starve),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    assign grant_ev    = (state == ST_IDLE) && bus.init_done && (|req);
    assign timeout_hit = (state == ST_ISSUE) && !bus.dn_start && (timer == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge mem_clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (grant_ev) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (bus.dn_start && bus.dn_done) state_nxt = ST_RELEASE;
                else if (bus.dn_start)           state_nxt = ST_BUSY;
                else if (timeout_hit)            state_nxt = ST_RELEASE;
            end
            ST_BUSY:    if (bus.dn_done) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst) begin
            win_oh     <= '0;
            req_done_q <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            len_q      <= '0;
            timer      <= '0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) loss_cnt[i] <= '0;
        end else begin
            // Completion is registered so it appears exactly in the RELEASE cycle.
            req_done_q <= (state != ST_RELEASE && state_nxt == ST_RELEASE) ? win_oh : '0;
            timer      <= (state == ST_ISSUE) ? timer + 16'd1 : '0;
            if (timeout_hit) timeout_q <= 1'b1;

            if (grant_ev) begin
                win_oh    <= pick_gnt;
                rd_addr_q <= '0;
                wr_addr_q <= '0;
                len_q     <= '0;
                case (pick_idx)
                    REQ_INS: begin
                        rd_addr_q <= bus.ins_read_addr;
                        len_q     <= bus.ins_read_len;
                    end
                    REQ_STORE: wr_addr_q <= bus.data_write_addr;
                    REQ_JMP:   rd_addr_q <= bus.jmp_read_addr;
                    default:   rd_addr_q <= bus.data_read_addr;
                endcase
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pick_gnt[i] || !req[i])          loss_cnt[i] <= '0;
                    else if (loss_cnt[i] != STARVE_LIMIT) loss_cnt[i] <= loss_cnt[i] + 4'd1;
                end
            end else if (state == ST_RELEASE) begin
                win_oh    <= '0;
                rd_addr_q <= '0;
                wr_addr_q <= '0;
                len_q     <= '0;
            end
        end
    end

    assign bus.dn_req_vec    = (state == ST_ISSUE) ? win_oh : '0;
    assign bus.dn_read_addr  = rd_addr_q;
    assign bus.dn_write_addr = wr_addr_q;
    assign bus.dn_ins_len    = len_q;
    assign bus.req_done      = req_done_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Randomised bench for ddr_req_arbiter against a queue-free arithmetic model of the arbitration rules.
module tb_ddr_req_arbiter;

    localparam int STARVE = 8;

    logic mem_clk;
    logic rst;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   mcnt [4];

    ddr_req_arbiter_if #(.DDR_ADDR_WIDTH(28), .LEN_WIDTH(8)) bus ();

    ddr_req_arbiter #(
        .DDR_ADDR_WIDTH (28),
        .LEN_WIDTH      (8),
        .STARVE_LIMIT   (4'd8),
        .TIMEOUT_CYCLES (16'd1024)
    ) dut (
        .mem_clk (mem_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    function automatic logic [3:0] cur_req();
        return {bus.data_read_req, bus.jmp_addr_read_req, bus.data_store_req, bus.ins_read_req};
    endfunction

    task automatic set_req(input logic [3:0] v);
        {bus.data_read_req, bus.jmp_addr_read_req, bus.data_store_req, bus.ins_read_req} = v;
    endtask

    task automatic rand_addrs();
        bus.ins_read_addr   = 28'($urandom);
        bus.ins_read_len    = 8'($urandom);
        bus.data_write_addr = 28'($urandom);
        bus.jmp_read_addr   = 28'($urandom);
        bus.data_read_addr  = 28'($urandom);
    endtask

    // Starving requesters (lowest index) beat the fixed order jmp, store, data_read, ins.
    function automatic logic [3:0] model_pick(input logic [3:0] r);
        int order [4];
        order = '{2, 1, 3, 0};
        for (int i = 0; i < 4; i++)
            if (r[i] && mcnt[i] >= STARVE) return 4'(1 << i);
        for (int p = 0; p < 4; p++)
            if (r[order[p]]) return 4'(1 << order[p]);
        return 4'b0000;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            if (w[i] || !r[i]) mcnt[i] = 0;
            else if (mcnt[i] < STARVE) mcnt[i] = mcnt[i] + 1;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
    endtask

    task automatic grant_phase(input string tag, output logic [3:0] exp, output logic [3:0] obs);
        logic [3:0]  r;
        logic [27:0] erd, ewr;
        logic [7:0]  elen;
        int          lat;
        r = cur_req();
        exp = model_pick(r);
        model_update(r, exp);
        erd = '0; ewr = '0; elen = '0;
        case (exp)
            4'b0001: begin erd = bus.ins_read_addr; elen = bus.ins_read_len; end
            4'b0010: ewr = bus.data_write_addr;
            4'b0100: erd = bus.jmp_read_addr;
            4'b1000: erd = bus.data_read_addr;
            default: ;
        endcase
        lat = 0;
        do begin tick(); lat++; end while (bus.dn_req_vec === 4'b0000 && lat < 50);
        obs = bus.dn_req_vec;
        tot_cnt++;
        if (lat !== 1) $display("FAIL %s grant_latency: got %0d cycles want 1", tag, lat);
        else pass_cnt++;
        tot_cnt++;
        if (obs !== exp) $display("FAIL %s grant_vec: got %b want %b", tag, obs, exp);
        else pass_cnt++;
        tot_cnt++;
        if ({bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len} !== {erd, ewr, elen})
            $display("FAIL %s latched: got rd=%h wr=%h len=%h want rd=%h wr=%h len=%h", tag,
                     bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len, erd, ewr, elen);
        else pass_cnt++;
    endtask

    // mode 0: normal start/done, 1: start+done together, 2: withhold dn_start until timeout
    task automatic finish_phase(input string tag, input logic [3:0] exp,
                                input int sdly, input int ddly, input int mode);
        int n;
        if (mode == 2) begin
            n = 0;
            while (bus.req_done === 4'b0000 && n < 1100) begin tick(); n++; end
            tot_cnt++;
            if (n !== 1024) $display("FAIL %s timeout_cycles: got %0d want 1024", tag, n);
            else pass_cnt++;
            tot_cnt++;
            if (bus.timeout_err !== 1'b1) $display("FAIL %s timeout_err: got %b want 1", tag, bus.timeout_err);
            else pass_cnt++;
        end else begin
            repeat (sdly) tick();
            bus.dn_start = 1'b1;
            bus.dn_done  = (mode == 1);
            tick();
            bus.dn_start = 1'b0;
            bus.dn_done  = 1'b0;
            if (mode == 0) begin
                tot_cnt++;
                if (bus.dn_req_vec !== 4'b0000 || bus.busy !== 1'b1)
                    $display("FAIL %s busy_state: got vec=%b busy=%b want vec=0000 busy=1", tag, bus.dn_req_vec, bus.busy);
                else pass_cnt++;
                repeat (ddly) begin
                    bus.dn_start = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.dn_start = 1'b0;
                bus.dn_done  = 1'b1;
                tick();
                bus.dn_done  = 1'b0;
            end
        end
        tot_cnt++;
        if (bus.req_done !== exp) $display("FAIL %s req_done: got %b want %b", tag, bus.req_done, exp);
        else pass_cnt++;
        set_req(cur_req() & ~exp);
        tick();
        tot_cnt++;
        if ({bus.req_done, bus.busy, bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len} !== '0)
            $display("FAIL %s back_to_idle: got done=%b busy=%b vec=%b rd=%h wr=%h len=%h want all 0", tag,
                     bus.req_done, bus.busy, bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len);
        else pass_cnt++;
    endtask

    task automatic do_txn(input string tag, input int sdly, input int ddly, input int mode,
                          output logic [3:0] obs);
        logic [3:0] exp;
        grant_phase(tag, exp, obs);
        finish_phase(tag, exp, sdly, ddly, mode);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.init_done = 1'b0;
        bus.dn_start  = 1'b0;
        bus.dn_done   = 1'b0;
        set_req(4'b0000);
        rand_addrs();
        model_clear();
        repeat (3) tick();
        tot_cnt++;
        if ({bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len, bus.req_done, bus.timeout_err, bus.busy} !== '0)
            $display("FAIL reset_outputs: got vec=%b rd=%h wr=%h len=%h done=%b to=%b busy=%b want all 0",
                     bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len, bus.req_done, bus.timeout_err, bus.busy);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_init_gate();
        logic [3:0] obs;
        int nz;
        nz = 0;
        rand_addrs();
        set_req(4'b0001);
        repeat (20) begin
            tick();
            if (bus.dn_req_vec !== 4'b0000 || bus.busy !== 1'b0) nz++;
        end
        tot_cnt++;
        if (nz !== 0) $display("FAIL init_gate: got %0d granted cycles want 0", nz);
        else pass_cnt++;
        bus.init_done = 1'b1;
        do_txn("init_gate", 0, 0, 0, obs);
    endtask

    task automatic test_priority();
        logic [3:0] obs [4];
        logic [3:0] want [4];
        want = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
        rand_addrs();
        set_req(4'b1111);
        for (int k = 0; k < 4; k++) do_txn("priority", $urandom_range(0, 2), $urandom_range(0, 2), 0, obs[k]);
        for (int k = 0; k < 4; k++) begin
            tot_cnt++;
            if (obs[k] !== want[k]) $display("FAIL priority_order[%0d]: got %b want %b", k, obs[k], want[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_starvation();
        logic [3:0] obs;
        int losses;
        bit got_ins;
        losses = 0;
        got_ins = 1'b0;
        set_req(4'b1111);
        for (int r = 0; r < 12 && !got_ins; r++) begin
            rand_addrs();
            do_txn("starve", 0, 0, 0, obs);
            if (obs === 4'b0001) got_ins = 1'b1;
            else begin
                losses++;
                set_req(cur_req() | obs);
            end
        end
        tot_cnt++;
        if (!got_ins || losses !== STARVE) $display("FAIL starvation: got granted=%0d after %0d losses want granted after 8", got_ins, losses);
        else pass_cnt++;
        for (int g = 0; g < 6 && cur_req() !== 4'b0000; g++) do_txn("drain", 0, 1, 0, obs);
    endtask

    task automatic test_same_cycle();
        logic [3:0] obs;
        rand_addrs();
        set_req(4'b0010);
        do_txn("same_cycle", 1, 0, 1, obs);
    endtask

    task automatic test_timeout();
        logic [3:0] obs;
        rand_addrs();
        set_req(4'b1100);
        do_txn("timeout", 0, 0, 2, obs);
        tot_cnt++;
        if (obs !== 4'b0100) $display("FAIL timeout_winner: got %b want 0100", obs);
        else pass_cnt++;
        do_txn("after_timeout", 0, 0, 0, obs);
        tot_cnt++;
        if (obs !== 4'b1000 || bus.timeout_err !== 1'b1)
            $display("FAIL after_timeout: got vec=%b err=%b want vec=1000 err=1", obs, bus.timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp, obs;
        rand_addrs();
        set_req(4'b0001);
        grant_phase("reset_mid", exp, obs);
        bus.dn_start = 1'b1;
        tick();
        bus.dn_start = 1'b0;
        tick();
        tot_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL reset_mid_busy: got busy=%b want 1", bus.busy);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        model_clear();
        tot_cnt++;
        if ({bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len, bus.req_done, bus.timeout_err, bus.busy} !== '0)
            $display("FAIL reset_mid_outputs: got vec=%b rd=%h wr=%h len=%h done=%b to=%b busy=%b want all 0",
                     bus.dn_req_vec, bus.dn_read_addr, bus.dn_write_addr, bus.dn_ins_len, bus.req_done, bus.timeout_err, bus.busy);
        else pass_cnt++;
        rst = 1'b1;
        do_txn("reset_mid_resume", 0, 0, 0, obs);
    endtask

    task automatic test_random();
        logic [3:0] v, obs;
        for (int r = 0; r < 30; r++) begin
            rand_addrs();
            if (cur_req() === 4'b0000) begin
                bus.dn_done = 1'b1;
                tick();
                bus.dn_done = 1'b0;
                tot_cnt++;
                if (bus.busy !== 1'b0) $display("FAIL idle_dn_done: got busy=%b want 0", bus.busy);
                else pass_cnt++;
            end
            v = cur_req() | 4'($urandom);
            if (v == 4'b0000) v = 4'(1 << $urandom_range(0, 3));
            set_req(v);
            do_txn("random", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), obs);
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_priority();
        test_starvation();
        test_same_cycle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
